// File: rtl/adc_frame_serializer.sv
// Frame serializer: hold_reg buffers the next frame, shift_reg sends MSB-first; define ADC_FRAME_SERIALIZER_PARITY_EN to append an even-parity bit.
// Latency: tx_start two cycles after accept when idle; frame_ready stays low while hold_reg is full.
`timescale 1ns/1ps
module adc_frame_serializer #(
    parameter int FRAME_BITS = 1024,
    parameter int CNT_W      = 11,
    parameter int BIT_PERIOD = 1,
    parameter int DIV_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    input  logic [FRAME_BITS-1:0] frame_din,
    output logic                  tx_start,
    output logic                  tx_bit,
    output logic                  tx_bit_valid,
    output logic                  pkt_done,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, START, SHIFT, DONE} state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    state_t                state;
    logic [FRAME_BITS-1:0] hold_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  hold_full;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DIV_W-1:0]      div_cnt;
    logic                  strobe;
    logic                  accept;

    assign frame_ready = ~hold_full & ~rst;
    assign accept      = frame_valid & frame_ready;
    assign strobe      = (state == SHIFT) && (div_cnt == DIV_LAST);

`ifdef ADC_FRAME_SERIALIZER_PARITY_EN
    localparam logic [CNT_W-1:0] CNT_PAR = CNT_W'(FRAME_BITS);
    logic par_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_acc <= 1'b0;
        end else if (state == START) begin
            par_acc <= 1'b0;
        end else if (strobe) begin
            par_acc <= par_acc ^ shift_reg[FRAME_BITS-1];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_reg  <= '0;
            shift_reg <= '0;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
        end else begin
            if (accept) begin
                hold_reg  <= frame_din;
                hold_full <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (hold_full) state <= START;
                end
                START: begin
                    shift_reg <= hold_reg;
                    hold_full <= 1'b0;
                    bit_cnt   <= '0;
                    div_cnt   <= '0;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    if (strobe) begin
                        div_cnt   <= '0;
                        shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
`ifdef ADC_FRAME_SERIALIZER_PARITY_EN
                        if (bit_cnt == CNT_PAR) begin
                            state <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            // After the last data bit the parity bit takes the MSB slot so tx_bit shows it
                            if (bit_cnt == CNT_LAST)
                                shift_reg <= {par_acc ^ shift_reg[FRAME_BITS-1], {(FRAME_BITS-1){1'b0}}};
                        end
`else
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_LAST) state <= DONE;
`endif
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DONE: begin
                    state <= hold_full ? START : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low during the reset cycle itself, before the registers clear
    assign tx_start     = ~rst & (state == START);
    assign tx_bit       = ~rst & shift_reg[FRAME_BITS-1];
    assign tx_bit_valid = ~rst & strobe;
    assign pkt_done     = ~rst & (state == DONE);
    assign busy         = ~rst & (state != IDLE);

endmodule

// File: tb/tb_adc_frame_serializer.sv
// Bench for adc_frame_serializer: two instances (BIT_PERIOD 1 and 3), each with a driver and a scoreboard monitor.
`timescale 1ns/1ps
module tb_adc_frame_serializer;
    localparam int FB = 8;
`ifdef ADC_FRAME_SERIALIZER_PARITY_EN
    localparam int NS = FB + 1;
`else
    localparam int NS = FB;
`endif

    typedef struct {
        logic [FB-1:0] d;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int gi, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s inst=%0d cyc=%0d actual=%0h required=%0h", name, gi, cyc, act, req);
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int GI = g;
        localparam int BP = (g == 0) ? 1 : 3;

        logic          rst = 1'b1;
        logic          frame_valid = 1'b0;
        logic [FB-1:0] frame_din = '0;
        logic          frame_ready, tx_start, tx_bit, tx_bit_valid, pkt_done, busy;
        exp_t          q[$];
        bit            done_f = 1'b0;

        adc_frame_serializer #(
            .FRAME_BITS(FB), .CNT_W(4), .BIT_PERIOD(BP), .DIV_W(3)
        ) dut (
            .clk(clk), .rst(rst),
            .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_din(frame_din),
            .tx_start(tx_start), .tx_bit(tx_bit), .tx_bit_valid(tx_bit_valid),
            .pkt_done(pkt_done), .busy(busy)
        );

        task automatic idle(input int n);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        endtask

        // Called at posedge+1; returns at posedge+1 after the accepting edge
        task automatic send(input logic [FB-1:0] d);
            bit ok = 1'b0;
            frame_valid = 1'b1;
            frame_din   = d;
            for (int i = 0; i < 200 && !ok; i++) begin
                @(negedge clk);
                if (frame_ready) begin
                    q.push_back('{d, cyc});
                    ok = 1'b1;
                end
                @(posedge clk);
                #1;
            end
            frame_valid = 1'b0;
            frame_din   = FB'($urandom_range(0, 255));
            chk("send_accept", GI, 32'(ok), 32'd1);
        endtask

        initial begin : driver
            int s;
            idle(3);
            rst = 1'b0;
            send(8'hA5); idle(NS*BP + 4);
            send(8'h81); idle(NS*BP + 4);
            send(8'hFF); send(8'h00); send(8'h5A); idle(3*(NS*BP + 2) + 4);
            send(8'hC3);
            s = 0;
            for (int i = 0; i < 200 && s < 3; i++) begin
                @(negedge clk);
                if (tx_bit_valid) s++;
            end
            chk("strobe_wait", GI, 32'(s), 32'd3);
            @(posedge clk); #1; rst = 1'b1;
            @(posedge clk); #1; rst = 1'b0;
            send(8'h3C); idle(NS*BP + 4);
            send(8'h07); idle(NS*BP + 4);
            send(8'h03); idle(NS*BP + 4);
            repeat (12) begin
                send(FB'($urandom_range(0, 255)));
                idle($urandom_range(0, 3));
            end
            idle(4*(NS*BP + 2) + 4);
            done_f = 1'b1;
        end

        initial begin : monitor
            bit   active = 1'b0;
            int   t0 = 0;
            int   last_done = -100;
            int   held;
            int   t;
            bit   seq[NS];
            exp_t e;
            logic e_start, e_valid, e_bit, e_done, e_busy;
            forever begin
                @(negedge clk);
                #1;
                if (rst) begin
                    chk("rst_outputs", GI, 32'({tx_start, tx_bit, tx_bit_valid, pkt_done, busy, frame_ready}), 32'd0);
                    active    = 1'b0;
                    last_done = -100;
                    q.delete();
                end else begin
                    held = 0;
                    foreach (q[i]) if (q[i].acc < cyc) held++;
                    chk("frame_ready", GI, 32'(frame_ready), 32'(held == 0));
                    if (!active && q.size() > 0 && cyc >= q[0].acc + 2 && cyc >= last_done + 1) begin
                        e      = q.pop_front();
                        active = 1'b1;
                        t0     = cyc;
                        for (int i = 0; i < FB; i++) seq[i] = e.d[FB-1-i];
`ifdef ADC_FRAME_SERIALIZER_PARITY_EN
                        seq[NS-1] = ^e.d;
`endif
                    end
                    e_start = 1'b0; e_valid = 1'b0; e_bit = 1'b0; e_done = 1'b0; e_busy = 1'b0;
                    if (active) begin
                        t       = cyc - t0;
                        e_busy  = 1'b1;
                        e_start = (t == 0);
                        e_valid = (t >= 1) && (t <= NS*BP) && (t % BP == 0);
                        e_bit   = ((t >= 1) && (t <= NS*BP)) ? seq[(t-1)/BP] : 1'b0;
                        e_done  = (t == NS*BP + 1);
                        if (e_done) begin
                            active    = 1'b0;
                            last_done = cyc;
                        end
                    end
                    chk("tx_start", GI, 32'(tx_start), 32'(e_start));
                    chk("tx_bit_valid", GI, 32'(tx_bit_valid), 32'(e_valid));
                    chk("tx_bit", GI, 32'(tx_bit), 32'(e_bit));
                    chk("pkt_done", GI, 32'(pkt_done), 32'(e_done));
                    chk("busy", GI, 32'(busy), 32'(e_busy));
                end
            end
        end
    end

    initial begin : main
        bit fin = 1'b0;
        for (int i = 0; i < 60000 && !fin; i++) begin
            @(posedge clk);
            fin = inst[0].done_f && inst[1].done_f;
        end
        chk("run_complete", -1, 32'(fin), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/adc_frame_serializer.md
Name: adc_frame_serializer

Overview:
- Transmit-side counterpart of the ADC frame receive buffer.
- Accepts a parallel frame through a valid/ready handshake into a holding register (buf2), copies it into a shift register (buf1), and shifts it out MSB-first as a strobed serial bit stream.
- Signalling matches the receive side exactly: start pulse, bit/valid pair, pkt_done pulse.
- Sits between the command/frame generator and the serial link driver; the link stays back-to-back because the next frame can be held while the current one shifts.

Parameters:
- FRAME_BITS, 1024, bits per frame (>= 2).
- CNT_W, 11, width of bit counter; must satisfy 2^CNT_W > FRAME_BITS.
- BIT_PERIOD, 1, clk cycles per serial bit (>= 1).
- DIV_W, 8, width of bit-period divider; must satisfy 2^DIV_W >= BIT_PERIOD.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- frame_valid  in  1  frame_din holds a frame.
- frame_ready  out  1  holding register empty; frame accepted when frame_valid & frame_ready.
- frame_din  in  FRAME_BITS  frame; bit FRAME_BITS-1 is sent first.
- tx_start  out  1  one-cycle pulse marking start of a frame (receiver clears its shift register on it).
- tx_bit  out  1  serial data; valid when tx_bit_valid = 1.
- tx_bit_valid  out  1  one-cycle strobe per transmitted bit.
- pkt_done  out  1  one-cycle pulse after the last bit of a frame.
- busy  out  1  high from START through DONE inclusive.

Behaviour:
- Reset: all registers cleared on any clk edge with rst = 1, including the state machine, counters, shift register, hold register and hold_full.
  - All outputs are 0 while rst = 1; frame_ready is gated to 0 during reset.
  - frame_ready is 1 on the first cycle after rst deasserts.
  - Reset mid-frame aborts the frame: no further strobes, no pkt_done, and any held frame is discarded.
- Handshake: frame_ready = ~hold_full & ~rst.
  - On accept: hold_reg <= frame_din and hold_full <= 1.
  - frame_din is sampled only on the accept cycle.
- FSM states: IDLE, START, SHIFT, DONE.
  - IDLE: busy = 0. If hold_full, go to START.
  - START (1 cycle): tx_start = 1; shift_reg <= hold_reg; hold_full <= 0 (frame_ready rises next cycle); bit_cnt <= 0; div_cnt <= 0. Go to SHIFT.
  - SHIFT: div_cnt counts 0..BIT_PERIOD-1. When it wraps:
    - tx_bit_valid = 1 for that one cycle, with tx_bit = shift_reg[FRAME_BITS-1].
    - shift_reg shifts left with 0 fill; bit_cnt increments.
    - After strobe number FRAME_BITS, go to DONE.
  - DONE (1 cycle): pkt_done = 1. Go to START if hold_full (including a frame accepted during this cycle's previous edge); otherwise go to IDLE.
- Timing: with the START cycle at T, strobe k (k = 1..FRAME_BITS) occurs at T + k*BIT_PERIOD, and pkt_done occurs at T + FRAME_BITS*BIT_PERIOD + 1.
  - With BIT_PERIOD = 1, tx_bit_valid is continuous for FRAME_BITS cycles.
  - Back-to-back frame spacing is FRAME_BITS*BIT_PERIOD + 2 cycles.
- tx_bit always equals shift_reg[FRAME_BITS-1], so it is stable between strobes and 0 in IDLE after reset.
- Accepting a new frame into the hold register while shifting never disturbs shift_reg.
- frame_valid held high with hold_full = 1 stalls with no loss of data.

Optional Feature:
- Macro: ADC_FRAME_SERIALIZER_PARITY_EN.
- Defined:
  - A running XOR of the transmitted data bits is cleared in START.
  - After strobe FRAME_BITS, one extra strobe is sent BIT_PERIOD cycles later, carrying even parity (the XOR of all FRAME_BITS data bits); tx_bit shows the parity value during that slot.
  - pkt_done follows the parity strobe by 1 cycle.
  - Total strobes per frame = FRAME_BITS+1.
- Undefined: no parity logic; exactly FRAME_BITS strobes per frame.

Test Plan:
- FRAME_BITS=8, BIT_PERIOD=1, send 8'hA5 -> tx_start at T; tx_bit sequence 1,0,1,0,0,1,0,1 at T+1..T+8; pkt_done at T+9; busy falls at T+10.
- FRAME_BITS=8, BIT_PERIOD=3, send 8'h81 -> strobes at T+3, T+6, ..., T+24 carrying 1,0,0,0,0,0,0,1; tx_bit unchanged between strobes; pkt_done at T+25.
- Two frames 8'hFF then 8'h00 offered back-to-back with frame_valid held high -> second frame accepted on the cycle after START of the first; second tx_start in the cycle after the first pkt_done; 16 correct bits; no gaps beyond 2 cycles.
- Third frame offered while the hold register is full -> frame_ready = 0 until the second frame's START; all three frames transmitted intact and in order.
- rst pulsed at strobe 4 of 8'hC3 -> no further strobes, no pkt_done, outputs 0, frame_ready = 1 the cycle after rst; a following frame 8'h3C transmits correctly.
- With ADC_FRAME_SERIALIZER_PARITY_EN, FRAME_BITS=8, send 8'h07 -> 9 strobes, 9th carries 1; send 8'h03 -> 9th carries 0; pkt_done 1 cycle after the 9th strobe.
